// File: rtl/noise_pkg.sv
// Shared types and helpers for the LFSR noise packer: FSM encoding, defaults,
// and the offset-binary to two's-complement conversion with attenuation.
package noise_pkg;

   localparam int         MAX_WIDTH = 24;
   localparam int         DEF_WIDTH = 16;
   localparam logic [3:0] DEF_SEED  = 4'b0011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEED = 2'd1,
      ST_FILL = 2'd2,
      ST_HOLD = 2'd3
   } state_t;

   // The word is aligned to the top of a MAX_WIDTH container so the arithmetic
   // shift sign-extends correctly for any width; the caller keeps the low bits.
   function automatic logic [MAX_WIDTH-1:0] to_noise(input logic [MAX_WIDTH-1:0] raw,
                                                     input int width,
                                                     input logic [2:0] atten);
      logic signed [MAX_WIDTH-1:0] aligned;
      int pad;
      pad     = MAX_WIDTH - width;
      aligned = signed'((raw << pad) ^ {1'b1, {(MAX_WIDTH-1){1'b0}}});
      return aligned >>> (pad + int'(atten));
   endfunction

endpackage

// File: rtl/noise_out_reg.sv
// One-entry valid/ready output register; load must only be asserted when the
// entry is free or being consumed on the same edge.
module noise_out_reg
   import noise_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] data,
   input  logic             ready,
   output logic [WIDTH-1:0] sample,
   output logic             valid
);

   logic [WIDTH-1:0] sample_r;
   logic             valid_r;

   // Output entry: a new load wins over a same-edge transfer, giving no bubble.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sample_r <= {WIDTH{1'b0}};
         valid_r  <= 1'b0;
      end else if (load) begin
         sample_r <= data;
         valid_r  <= 1'b1;
      end else if (valid_r && ready) begin
         valid_r  <= 1'b0;
      end else begin
         valid_r  <= valid_r;
      end
   end

   assign sample = sample_r;
   assign valid  = valid_r;

endmodule

// File: rtl/lfsr_noise_packer.sv
// Packs the serial LFSR bitstream into attenuated signed noise samples, seeds the
// LFSR, and forces a reseed when it produces consecutive all-zero words.
module lfsr_noise_packer
   import noise_pkg::*;
#(
   parameter int         WIDTH       = DEF_WIDTH,
   parameter logic [3:0] SEED        = DEF_SEED,
   parameter int         LOAD_CYCLES = 2,
   parameter int         STUCK_LIMIT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             lfsr_q,
   input  logic [2:0]       atten,
   output logic             lfsr_load,
   output logic [3:0]       lfsr_seed,
   output logic [WIDTH-1:0] sample,
   output logic             sample_valid,
   input  logic             sample_ready,
   output logic             stuck
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int LW = $clog2(LOAD_CYCLES + 1);
   localparam int ZW = $clog2(STUCK_LIMIT + 1);
   localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);
   localparam logic [LW-1:0] LOAD_LAST = LW'(LOAD_CYCLES - 1);
   localparam logic [ZW-1:0] ZERO_LAST = ZW'(STUCK_LIMIT - 1);

   state_t               state_r, next_state_s;
   logic [CW-1:0]        bit_cnt_r;
   logic [LW-1:0]        load_cnt_r;
   logic [ZW-1:0]        zero_cnt_r;
   logic [WIDTH-1:0]     shift_r;
   logic [WIDTH-1:0]     hold_r;
   logic                 load_r;
   logic                 stuck_r;

   logic [WIDTH-1:0]     shifted_s;
   logic [MAX_WIDTH-1:0] conv_full_s;
   logic [WIDTH-1:0]     conv_s;
   logic                 word_done_s;
   logic                 raw_zero_s;
   logic                 out_free_s;
   logic                 out_load_s;
   logic [WIDTH-1:0]     out_data_s;
   logic                 stuck_s;

   assign shifted_s   = {shift_r[WIDTH-2:0], lfsr_q};
   assign conv_full_s = to_noise(MAX_WIDTH'(shifted_s), WIDTH, atten);
   assign conv_s      = conv_full_s[WIDTH-1:0];
   assign word_done_s = (state_r == ST_FILL) && (bit_cnt_r == LAST_BIT);
   assign raw_zero_s  = (shifted_s == {WIDTH{1'b0}});
   assign out_free_s  = !sample_valid || sample_ready;

   // Next-state and output-register load decisions.
   always_comb begin
      next_state_s = state_r;
      out_load_s   = 1'b0;
      out_data_s   = conv_s;
      stuck_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (en) next_state_s = ST_SEED;
            else    next_state_s = ST_IDLE;
         end
         ST_SEED: begin
            if (!en)                          next_state_s = ST_IDLE;
            else if (load_cnt_r == LOAD_LAST) next_state_s = ST_FILL;
            else                              next_state_s = ST_SEED;
         end
         ST_FILL: begin
            if (!en) begin
               next_state_s = ST_IDLE;
            end else if (word_done_s && raw_zero_s) begin
               if (zero_cnt_r == ZERO_LAST) begin
                  stuck_s      = 1'b1;
                  next_state_s = ST_SEED;
               end else begin
                  next_state_s = ST_FILL;
               end
            end else if (word_done_s && out_free_s) begin
               out_load_s   = 1'b1;
               next_state_s = ST_FILL;
            end else if (word_done_s) begin
               next_state_s = ST_HOLD;
            end else begin
               next_state_s = ST_FILL;
            end
         end
         ST_HOLD: begin
            if (!en) begin
               next_state_s = ST_IDLE;
            end else if (out_free_s) begin
               out_load_s   = 1'b1;
               out_data_s   = hold_r;
               next_state_s = ST_FILL;
            end else begin
               next_state_s = ST_HOLD;
            end
         end
         default: next_state_s = ST_IDLE;
      endcase
   end

   // Sequencing state, counters, shift/hold datapath and registered strobes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= ST_IDLE;
         bit_cnt_r  <= {CW{1'b0}};
         load_cnt_r <= {LW{1'b0}};
         zero_cnt_r <= {ZW{1'b0}};
         shift_r    <= {WIDTH{1'b0}};
         hold_r     <= {WIDTH{1'b0}};
         load_r     <= 1'b0;
         stuck_r    <= 1'b0;
      end else begin
         state_r <= next_state_s;
         load_r  <= (next_state_s == ST_SEED);
         stuck_r <= stuck_s;

         if (state_r == ST_SEED && next_state_s == ST_SEED) load_cnt_r <= load_cnt_r + 1'b1;
         else                                               load_cnt_r <= {LW{1'b0}};

         if (state_r == ST_FILL && next_state_s == ST_FILL && !word_done_s)
            bit_cnt_r <= bit_cnt_r + 1'b1;
         else
            bit_cnt_r <= {CW{1'b0}};

         if (next_state_s == ST_SEED)  shift_r <= {WIDTH{1'b0}};
         else if (state_r == ST_FILL)  shift_r <= shifted_s;
         else                          shift_r <= shift_r;

         if (!en || stuck_s)                 zero_cnt_r <= {ZW{1'b0}};
         else if (word_done_s && raw_zero_s) zero_cnt_r <= zero_cnt_r + 1'b1;
         else if (word_done_s)               zero_cnt_r <= {ZW{1'b0}};
         else                                zero_cnt_r <= zero_cnt_r;

         if (word_done_s && next_state_s == ST_HOLD) hold_r <= conv_s;
         else                                        hold_r <= hold_r;
      end
   end

   noise_out_reg #(.WIDTH(WIDTH)) u_out (
      .clk    (clk),
      .rst    (rst),
      .load   (out_load_s),
      .data   (out_data_s),
      .ready  (sample_ready),
      .sample (sample),
      .valid  (sample_valid)
   );

   assign lfsr_load = load_r;
   assign lfsr_seed = SEED;
   assign stuck     = stuck_r;

endmodule

// File: doc/lfsr_noise_packer.md
Name: lfsr_noise_packer

Overview:
- Downstream consumer of the 4-bit LFSR serial output `q`, and owner of that LFSR's seed/load controls.
- Packs the LFSR bitstream into WIDTH-bit signed noise samples for the karaoke audio mixer (breath/hiss effect).
- Applies a programmable attenuation and detects a stuck (all-zero) LFSR, forcing a reseed.
- Output is a valid/ready stream, registered, one sample deep.

Parameters:
- WIDTH, 16: sample width in bits; legal range 8..24.
- SEED, 4'b0011: value driven on lfsr_seed.
- LOAD_CYCLES, 2: number of cycles lfsr_load is held high per seed operation.
- STUCK_LIMIT, 2: consecutive all-zero raw words that trigger a reseed.

Ports:
- clk, in, 1: single clock; every register is on its rising edge.
- rst, in, 1: asynchronous, active-low reset; rst=0 resets immediately, release is synchronous to clk.
- en, in, 1: noise enable.
- lfsr_q, in, 1: serial bit from the LFSR, sampled every clk in FILL.
- atten, in, 3: arithmetic right-shift amount, 0..7; sampled when a word completes.
- lfsr_load, out, 1: load strobe to the LFSR.
- lfsr_seed, out, 4: seed to the LFSR; constant SEED.
- sample, out, WIDTH: signed noise sample.
- sample_valid, out, 1: sample holds a new value.
- sample_ready, in, 1: consumer accepts the sample.
- stuck, out, 1: one-cycle pulse when a reseed is forced.

Behaviour:
- Reset values:
  - FSM=IDLE, bit counter=0, shift register=0, zero counter=0.
  - sample=0, sample_valid=0, lfsr_load=0, stuck=0.
  - lfsr_seed=SEED (constant, including during reset).
- FSM states: IDLE, SEED, FILL, HOLD.
- IDLE:
  - en=1 moves to SEED.
- SEED:
  - lfsr_load=1 for exactly LOAD_CYCLES cycles, then FILL.
  - Bit counter and shift register are cleared on entry.
- FILL:
  - Every cycle, shift = {shift[WIDTH-2:0], lfsr_q} (MSB-first); count++.
  - The word completes on the edge that captures bit WIDTH-1.
- Word completion, raw word = shifted result:
  - raw == 0:
    - Word is discarded; zero counter++.
    - When the zero counter reaches STUCK_LIMIT: stuck=1 for one cycle, zero counter clears, go to SEED.
    - Otherwise restart FILL with count=0.
  - raw != 0:
    - Zero counter clears.
    - Converted value = raw with MSB inverted (offset-binary to two's complement), then arithmetic right shift by atten.
    - If the output register is free, or is being consumed this same cycle (sample_valid & sample_ready), load sample, set sample_valid=1, stay in FILL with count=0.
    - Otherwise go to HOLD.
- HOLD:
  - Shifting stops; LFSR bits arriving meanwhile are dropped.
  - The converted word is retained.
  - When the output register frees, it loads in that same cycle; return to FILL.
- Output handshake:
  - sample and sample_valid are stable while valid=1 and ready=0.
  - A transfer occurs on an edge where valid=1 and ready=1.
  - valid drops after the transfer unless a new word loads on the same edge (back-to-back, no bubble).
- Latency: sample_valid rises on edge number WIDTH after the first FILL edge.
- en=0 in any state:
  - Next edge goes to IDLE; partial word, held word and zero counter are discarded.
  - lfsr_load drops immediately (registered, next edge).
  - An already-valid output sample stays valid until handshaken.
- Reset asserted mid-operation: everything returns to reset values asynchronously; a pending sample is lost.
- Simultaneous word completion and output consumption: the new word loads, valid stays 1.

Decomposition:
- Shared package noise_pkg holds:
  - FSM state encoding (IDLE=0, SEED=1, FILL=2, HOLD=3).
  - Default SEED and WIDTH constants.
  - A function for the offset-binary conversion plus attenuation.
- One natural sub-module, noise_out_reg: the one-entry valid/ready output register.
- Everything else stays in lfsr_noise_packer.

Test Plan (WIDTH=8; the bench drives lfsr_q directly):
1. Reset and idle:
   - Stimulus: rst=0 for 2 cycles, en=0.
   - Response: sample=8'h00, sample_valid=0, lfsr_load=0, stuck=0, lfsr_seed=4'b0011.
2. Seed and first word:
   - Stimulus: en=1, then drive bits 1,0,1,0,0,1,1,0 with atten=0.
   - Response: lfsr_load high exactly 2 cycles; sample=8'h26 with valid high on the 8th FILL edge.
3. Attenuation:
   - Stimulus: raw word 8'h3C with atten=2.
   - Response: sample=8'hEF (-17).
4. Backpressure:
   - Stimulus: sample_ready=0 for 20 cycles while lfsr_q keeps toggling.
   - Response: the first sample is held stable; FSM reaches HOLD after the next 8 bits.
   - Then: ready=1 for one cycle gives the first sample accepted and the held word appearing the next cycle, valid continuous.
5. Stuck detection:
   - Stimulus: lfsr_q held 0.
   - Response: no valid for either zero word; after the 2nd zero word, stuck pulses one cycle and lfsr_load reasserts for 2 cycles.
6. Async reset mid-FILL:
   - Stimulus: rst=0 at bit 5, between clock edges.
   - Response: outputs clear without waiting for clk.
   - Then: on release with en=1, a full SEED sequence repeats.
